// File: rtl/output_collector.sv
// rtl/output_collector.sv - per-PE result slots serialised into addressed writes toward the output buffer
module output_collector #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int NUM_CH       = 64,
    parameter int CH_BITS      = $clog2(NUM_CH + 1),
    parameter int MAX_N        = 512,
    parameter int N_BITS       = $clog2(MAX_N + 1),
    parameter int DATA_W       = 32,
    parameter int ADDR_BITS    = 24,
    parameter int STALL_THRESH = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ROWS*COLS-1:0]           in_valid,
    input  logic [ROWS*COLS*N_BITS-1:0]    in_row,
    input  logic [ROWS*COLS*N_BITS-1:0]    in_col,
    input  logic [ROWS*COLS*CH_BITS-1:0]   in_channel,
    input  logic [ROWS*COLS*DATA_W-1:0]    in_data,
    input  logic [N_BITS-1:0]              out_width,
    input  logic [N_BITS-1:0]              out_height,
    input  logic [CH_BITS-1:0]             num_channels,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [ADDR_BITS-1:0]           wr_addr,
    output logic [DATA_W-1:0]              wr_data,
    output logic                           stall_req,
    output logic                           busy,
    output logic                           overflow,
    input  logic                           clear_overflow
);

    localparam int NPE      = ROWS * COLS;
    localparam int IDX_BITS = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int CNT_BITS = $clog2(NPE + 1);

    logic [NPE-1:0]     occ;
    logic [N_BITS-1:0]  slot_row  [NPE];
    logic [N_BITS-1:0]  slot_col  [NPE];
    logic [CH_BITS-1:0] slot_ch   [NPE];
    logic [DATA_W-1:0]  slot_data [NPE];

    logic                 drain_found;
    logic [IDX_BITS-1:0]  drain_idx;
    logic                 drain_en;
    logic [CNT_BITS-1:0]  occ_count;
    logic [ADDR_BITS-1:0] addr_calc;
    logic [NPE-1:0]       occ_next;
    logic [NPE-1:0]       load;
    logic                 lost;

    // Lowest occupied index wins: scanning downward leaves the smallest hit last.
    always_comb begin
        drain_found = 1'b0;
        drain_idx   = '0;
        occ_count   = '0;
        for (int k = NPE - 1; k >= 0; k--) begin
            if (occ[k]) begin
                drain_found = 1'b1;
                drain_idx   = IDX_BITS'(k);
                occ_count   = occ_count + CNT_BITS'(1);
            end
        end
    end

    assign drain_en = drain_found && (!wr_valid || wr_ready);

    assign addr_calc = (ADDR_BITS'(slot_row[drain_idx]) * ADDR_BITS'(out_width)
                        + ADDR_BITS'(slot_col[drain_idx])) * ADDR_BITS'(num_channels)
                       + ADDR_BITS'(slot_ch[drain_idx]);

    // A slot that drains this edge is free to accept a new result on the same edge.
    always_comb begin
        occ_next = '0;
        load     = '0;
        lost     = 1'b0;
        for (int k = 0; k < NPE; k++) begin
            logic cap;
            logic keep;
            cap  = in_valid[k]
                   && (in_row[k*N_BITS +: N_BITS] < out_height)
                   && (in_col[k*N_BITS +: N_BITS] < out_width);
            keep = occ[k] && !(drain_en && (drain_idx == IDX_BITS'(k)));
            if (cap && keep) begin
                lost = 1'b1;
            end
            load[k]     = cap && !keep;
            occ_next[k] = keep || cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            stall_req <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            occ       <= occ_next;
            stall_req <= (occ_count >= CNT_BITS'(STALL_THRESH));
            if (drain_en) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr_calc;
                wr_data  <= slot_data[drain_idx];
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
            if (lost) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Slot payloads are qualified by occ, so they need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NPE; k++) begin
            if (load[k]) begin
                slot_row[k]  <= in_row[k*N_BITS +: N_BITS];
                slot_col[k]  <= in_col[k*N_BITS +: N_BITS];
                slot_ch[k]   <= in_channel[k*CH_BITS +: CH_BITS];
                slot_data[k] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign busy = (|occ) || wr_valid;

endmodule

// File: tb/tb_output_collector.sv
// tb/tb_output_collector.sv - randomized scoreboard bench for output_collector
module tb_output_collector;

    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int NPE          = ROWS * COLS;
    localparam int NUM_CH       = 64;
    localparam int CH_BITS      = $clog2(NUM_CH + 1);
    localparam int MAX_N        = 512;
    localparam int N_BITS       = $clog2(MAX_N + 1);
    localparam int DATA_W       = 32;
    localparam int ADDR_BITS    = 24;
    localparam int STALL_THRESH = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NPE-1:0]            in_valid;
    logic [NPE*N_BITS-1:0]     in_row;
    logic [NPE*N_BITS-1:0]     in_col;
    logic [NPE*CH_BITS-1:0]    in_channel;
    logic [NPE*DATA_W-1:0]     in_data;
    logic [N_BITS-1:0]         out_width;
    logic [N_BITS-1:0]         out_height;
    logic [CH_BITS-1:0]        num_channels;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_BITS-1:0]      wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      stall_req;
    logic                      busy;
    logic                      overflow;
    logic                      clear_overflow;

    output_collector #(
        .ROWS(ROWS), .COLS(COLS), .NUM_CH(NUM_CH), .MAX_N(MAX_N),
        .DATA_W(DATA_W), .ADDR_BITS(ADDR_BITS), .STALL_THRESH(STALL_THRESH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
        .in_channel(in_channel), .in_data(in_data),
        .out_width(out_width), .out_height(out_height), .num_channels(num_channels),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall_req(stall_req), .busy(busy), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    typedef struct {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_W-1:0]    data;
    } wr_t;

    wr_t exp_q[$];

    // Reference model: a set of pending results per PE plus one outstanding write.
    bit          m_occ  [NPE];
    int          m_row  [NPE];
    int          m_col  [NPE];
    int          m_ch   [NPE];
    logic [31:0] m_data [NPE];
    bit          m_out_v;
    bit          m_ovf;
    bit          m_stall;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    function automatic logic [ADDR_BITS-1:0] exp_addr(int r, int c, int ch);
        longint a;
        a = ((longint'(r) * longint'(out_width) + longint'(c)) * longint'(num_channels)
             + longint'(ch)) % (longint'(1) << ADDR_BITS);
        return a[ADDR_BITS-1:0];
    endfunction

    task automatic model_step();
        int  cnt;
        int  sel;
        bit  lost;
        if (reset) begin
            foreach (m_occ[k]) m_occ[k] = 1'b0;
            m_out_v = 1'b0;
            m_ovf   = 1'b0;
            m_stall = 1'b0;
            exp_q.delete();
            return;
        end
        cnt = 0;
        foreach (m_occ[k]) cnt += int'(m_occ[k]);
        m_stall = (cnt >= STALL_THRESH);
        if (!m_out_v || wr_ready) begin
            m_out_v = 1'b0;
            sel = -1;
            for (int k = NPE - 1; k >= 0; k--) if (m_occ[k]) sel = k;
            if (sel >= 0) begin
                m_occ[sel] = 1'b0;
                m_out_v    = 1'b1;
                exp_q.push_back('{exp_addr(m_row[sel], m_col[sel], m_ch[sel]), m_data[sel]});
            end
        end
        lost = 1'b0;
        for (int k = 0; k < NPE; k++) begin
            int r;
            int c;
            r = int'(in_row[k*N_BITS +: N_BITS]);
            c = int'(in_col[k*N_BITS +: N_BITS]);
            if (in_valid[k] && r < int'(out_height) && c < int'(out_width)) begin
                if (m_occ[k]) begin
                    lost = 1'b1;
                end else begin
                    m_occ[k]  = 1'b1;
                    m_row[k]  = r;
                    m_col[k]  = c;
                    m_ch[k]   = int'(in_channel[k*CH_BITS +: CH_BITS]);
                    m_data[k] = in_data[k*DATA_W +: DATA_W];
                end
            end
        end
        if (lost) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic fire(int k, int r, int c, int ch, logic [31:0] d);
        in_valid[k]                   = 1'b1;
        in_row[k*N_BITS +: N_BITS]    = N_BITS'(r);
        in_col[k*N_BITS +: N_BITS]    = N_BITS'(c);
        in_channel[k*CH_BITS +: CH_BITS] = CH_BITS'(ch);
        in_data[k*DATA_W +: DATA_W]   = d;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares status against the model and pops writes as the DUT transfers them.
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (done) begin
                chk("queue_empty", 64'(exp_q.size()), 64'd0);
                chk("busy_final", 64'(busy), 64'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            chk("wr_valid", 64'(wr_valid), 64'(m_out_v));
            chk("busy", 64'(busy), 64'(m_out_v || (m_occ.sum() with (int'(item)) != 0)));
            chk("stall_req", 64'(stall_req), 64'(m_stall));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (wr_valid && m_out_v) begin
                if (exp_q.size() == 0) begin
                    chk("write_expected", 64'd0, 64'd1);
                end else begin
                    chk("wr_addr", 64'(wr_addr), 64'(exp_q[0].addr));
                    chk("wr_data", 64'(wr_data), 64'(exp_q[0].data));
                    if (wr_ready && !reset) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        in_valid       = '0;
        in_row         = '0;
        in_col         = '0;
        in_channel     = '0;
        in_data        = '0;
        wr_ready       = 1'b1;
        clear_overflow = 1'b0;
        out_width      = N_BITS'(8);
        out_height     = N_BITS'(6);
        num_channels   = CH_BITS'(16);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        fire(0, 2, 3, 5, 32'hDEAD);
        tick(); in_valid = '0;
        repeat (4) tick();

        fire(3, 1, 1, 1, 32'h3333); fire(6, 2, 2, 2, 32'h6666);
        fire(9, 3, 3, 3, 32'h9999); fire(12, 4, 4, 4, 32'hCCCC);
        tick(); in_valid = '0;
        repeat (7) tick();

        fire(1, 5, 7, 15, 32'h1111);
        tick(); in_valid = '0;
        tick();
        wr_ready = 1'b0;
        repeat (5) tick();
        wr_ready = 1'b1;
        repeat (3) tick();

        wr_ready = 1'b0;
        fire(0, 0, 0, 0, 32'hA0A0); fire(5, 1, 2, 3, 32'h5555);
        tick(); in_valid = '0;
        repeat (2) tick();
        fire(5, 4, 4, 4, 32'hBAD5);
        tick(); in_valid = '0;
        repeat (2) tick();
        wr_ready = 1'b1;
        repeat (4) tick();
        clear_overflow = 1'b1;
        tick(); clear_overflow = 1'b0;
        repeat (2) tick();

        fire(2, int'(out_height), 0, 0, 32'hDEAD_BEEF);
        tick(); in_valid = '0;
        repeat (3) tick();

        wr_ready = 1'b0;
        for (int k = 0; k <= 12; k++) fire(k, k % 6, k % 8, k, 32'(k) + 32'h100);
        tick(); in_valid = '0;
        repeat (4) tick();
        wr_ready = 1'b1;
        repeat (20) tick();

        out_width    = N_BITS'(1000);
        out_height   = N_BITS'(1000);
        num_channels = CH_BITS'(64);
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < NPE; k++)
                if ($urandom_range(0, 3) == 0)
                    fire(k, $urandom_range(900, 999), $urandom_range(900, 999),
                         $urandom_range(0, 63), $urandom);
            wr_ready = ($urandom_range(0, 3) != 0);
            tick(); in_valid = '0;
        end
        wr_ready = 1'b1;
        repeat (30) tick();
        out_width    = N_BITS'(8);
        out_height   = N_BITS'(6);
        num_channels = CH_BITS'(16);

        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NPE; k++)
                if ($urandom_range(0, 9) < 2)
                    fire(k, $urandom_range(0, 6), $urandom_range(0, 8),
                         $urandom_range(0, 15), $urandom);
            wr_ready       = (n % 200 < 100) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            reset          = ($urandom_range(0, 299) == 0);
            tick();
            in_valid = '0;
        end
        reset          = 1'b0;
        clear_overflow = 1'b0;
        wr_ready       = 1'b1;
        repeat (40) tick();
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_end: got no summary expected summary");
        $fatal(1);
    end

endmodule

// File: doc/output_collector.md
# output_collector

Downstream neighbour of the systolic-array output coordinator. It captures the per-PE completion strobes, coordinates and accumulator values, holds each in a one-deep slot per PE, and serialises them into one addressed write per cycle toward the output activation buffer. It back-pressures the array through `stall_req` when slots run short, and flags lost results.

## Interface
- ROWS, 4, PE rows
- COLS, 4, PE columns
- NUM_CH, 64, max channels per layer
- CH_BITS, $clog2(NUM_CH+1), channel field width
- MAX_N, 512, max output dimension
- N_BITS, $clog2(MAX_N+1), row/col width
- DATA_W, 32, accumulator word width
- ADDR_BITS, 24, output buffer address width
- STALL_THRESH, 12, occupied-slot count at which stall is requested

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1 x ROWS*COLS  per-PE result complete this cycle
- in_row  in  N_BITS x ROWS*COLS  absolute output row per PE
- in_col  in  N_BITS x ROWS*COLS  absolute output col per PE
- in_channel  in  CH_BITS x ROWS*COLS  output channel per PE
- in_data  in  DATA_W x ROWS*COLS  PE accumulator value
- out_width  in  N_BITS  layer output width (quasi-static)
- out_height  in  N_BITS  layer output height (quasi-static)
- num_channels  in  CH_BITS  layer output channel count (quasi-static)
- wr_valid  out  1  write request
- wr_ready  in  1  buffer accepts write
- wr_addr  out  ADDR_BITS  (row*out_width + col)*num_channels + channel
- wr_data  out  DATA_W  accumulator value
- stall_req  out  1  request upstream stall
- busy  out  1  any slot occupied or wr_valid high
- overflow  out  1  sticky: a result was lost
- clear_overflow  in  1  clears overflow

## Operation
- One slot per PE (flat index i*COLS+j): occupied bit, row, col, channel, data.
- Capture: in_valid[k] high and in-bounds (row < out_height and col < out_width) → slot k loads on the next edge. Out-of-bounds results (edge tiles) are discarded silently; they do not set overflow.
- Capture into an occupied slot that is not drained on the same edge → new result discarded, overflow set to 1.
- Capture and drain of the same slot on the same edge → the slot reloads with the new result and stays occupied; no overflow.
- Drain: when the output register is empty or wr_ready is high, the lowest-index occupied slot moves into the output register (wr_valid, wr_addr, wr_data) and its occupied bit clears. Otherwise no slot drains.
- Handshake: wr_valid/wr_addr/wr_data are held stable while wr_valid && !wr_ready. A transfer occurs on an edge with wr_valid && wr_ready.
- Address: computed at ADDR_BITS width and truncated mod 2^ADDR_BITS; all operands are zero-extended.
- stall_req = registered occupied-slot count >= STALL_THRESH.
- overflow: sticky until clear_overflow. If clear_overflow and a new overflow occur on the same edge, set wins.
- busy = any occupied bit OR wr_valid.

## Timing
- Reset: all slots empty; wr_valid=0, wr_addr=0, wr_data=0, stall_req=0, overflow=0, busy=0. Reset mid-transfer drops all pending results without a write.
- Latency: in_valid at cycle t, all slots empty, wr_ready=1 → captured at edge t+1; wr_valid=1 in cycle t+2.
- Throughput: one write per cycle while wr_ready=1.
- stall_req lags occupancy by one cycle. STALL_THRESH leaves headroom for this lag.
- A full diagonal of ROWS simultaneous valids drains in ROWS consecutive cycles, in ascending flat index.

## Test plan
- Single PE 0 valid, row=2, col=3, ch=5, data=0xDEAD, out_width=8, num_channels=16 → wr_valid two cycles later, wr_addr=(2*8+3)*16+5=309, wr_data=0xDEAD.
- Valids on PEs 3, 6, 9, 12 in one cycle, wr_ready=1 → four consecutive writes in order 3, 6, 9, 12; busy drops the cycle after the last transfer.
- wr_ready=0 for 5 cycles while a write is pending → wr_addr/wr_data unchanged each cycle; transfer on the first wr_ready=1 edge.
- Hold wr_ready=0, re-fire PE 5 while slot 5 is occupied → overflow=1 and the first value is written later; clear_overflow → overflow=0.
- in_row=out_height on PE 2 → no write, overflow stays 0.
- wr_ready=0 with valids filling 12 slots → stall_req=1 the cycle after; drains to 11 → stall_req=0 one cycle later.
